// File: rtl/skeleton_frame_controller.sv
// Frame controller around the convolutional mask stage: holds the N*N image, replays it
// into the mask stage, collects the write-back stream and iterates thinning passes.
module skeleton_frame_controller #(
  parameter int N        = 8,
  parameter int bitSize  = 6,
  parameter int MAX_ITER = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [7:0]       load_data,
  input  logic             start,
  input  logic             wr_en,
  input  logic [bitSize:0] wr_addr,
  input  logic [7:0]       wr_data,
  output logic             mask_we,
  output logic [7:0]       mask_data,
  input  logic [bitSize:0] rd_addr,
  output logic [7:0]       rd_data,
  output logic             busy,
  output logic             done,
  output logic             converged,
  output logic             timeout,
  output logic [7:0]       iter_count,
  output logic [bitSize:0] changed_count
);

  localparam int AW = bitSize + 1;
  localparam int NN = N * N;
  localparam int MW = (NN > 1) ? $clog2(NN) : 1;
  localparam int RW = $clog2(2 * NN);
  localparam int TW = $clog2(4 * NN);
  localparam logic [AW:0]   NN_W  = NN[AW:0];
  localparam logic [MW-1:0] LLAST = MW'(NN - 1);
  localparam logic [RW-1:0] RLAST = RW'(2 * NN - 1);
  localparam logic [TW-1:0] TLAST = TW'(4 * NN - 1);
  localparam logic [7:0]    ITER_CAP = 8'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REPLAY,
    S_COLLECT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t         state;
  logic [7:0]     pix [NN];
  logic [MW-1:0]  load_ptr;
  logic [RW-1:0]  rep_cnt;
  logic [TW-1:0]  timer;
  logic           seen_wr;
  logic [AW-1:0]  last_addr;

  logic           host_wr;
  logic           wr_in_range;
  logic           rd_in_range;
  logic           accept;
  logic [MW-1:0]  wr_idx;
  logic [RW-1:0]  rep_next;
  logic [7:0]     next_pix;
  logic [7:0]     first_pix;
  logic [7:0]     iter_next;

  always_comb begin
    host_wr     = (state == S_IDLE) && load_valid;
    wr_in_range = ({1'b0, wr_addr} < NN_W);
    rd_in_range = ({1'b0, rd_addr} < NN_W);
    wr_idx      = wr_addr[MW-1:0];
    accept      = (state == S_COLLECT) && wr_en && wr_in_range &&
                  (!seen_wr || (wr_addr != last_addr));
    rep_next    = rep_cnt + 1'b1;
    next_pix    = pix[MW'(rep_next >> 1)];
    // A load to pixel 0 in the start cycle must be visible in the first replayed pixel.
    first_pix   = (host_wr && (load_ptr == '0)) ? load_data : pix[0];
    iter_next   = iter_count + 8'd1;
    rd_data     = rd_in_range ? pix[rd_addr[MW-1:0]] : '0;
  end

  // Image storage is deliberately left out of reset so a reset keeps the loaded frame.
  always_ff @(posedge clk) begin
    if (host_wr) begin
      pix[load_ptr] <= load_data;
    end else if (accept) begin
      pix[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      load_ptr      <= '0;
      rep_cnt       <= '0;
      timer         <= '0;
      seen_wr       <= 1'b0;
      last_addr     <= '0;
      mask_we       <= 1'b0;
      mask_data     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      converged     <= 1'b0;
      timeout       <= 1'b0;
      iter_count    <= '0;
      changed_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_valid) begin
            load_ptr <= (load_ptr == LLAST) ? '0 : load_ptr + 1'b1;
          end
          if (start) begin
            load_ptr   <= '0;
            state      <= S_REPLAY;
            rep_cnt    <= '0;
            mask_we    <= 1'b1;
            mask_data  <= first_pix;
            busy       <= 1'b1;
            done       <= 1'b0;
            iter_count <= '0;
            converged  <= 1'b0;
            timeout    <= 1'b0;
          end
        end

        S_REPLAY: begin
          if (rep_cnt == RLAST) begin
            state         <= S_COLLECT;
            mask_we       <= 1'b0;
            changed_count <= '0;
            seen_wr       <= 1'b0;
            last_addr     <= '0;
            timer         <= '0;
          end else begin
            rep_cnt   <= rep_next;
            mask_data <= next_pix;
          end
        end

        S_COLLECT: begin
          if (wr_en) begin
            seen_wr <= 1'b1;
            if (accept) begin
              last_addr <= wr_addr;
              if ((wr_data != pix[wr_idx]) && (changed_count != '1)) begin
                changed_count <= changed_count + 1'b1;
              end
            end
          end else if (seen_wr) begin
            state <= S_CHECK;
          end else if (timer == TLAST) begin
            state   <= S_DONE;
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_CHECK: begin
          iter_count <= iter_next;
          if (changed_count == '0) begin
            state     <= S_DONE;
            converged <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (iter_next == ITER_CAP) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= S_REPLAY;
            rep_cnt   <= '0;
            mask_we   <= 1'b1;
            mask_data <= pix[0];
          end
        end

        S_DONE: begin
          if (start) begin
            load_ptr   <= '0;
            state      <= S_REPLAY;
            rep_cnt    <= '0;
            mask_we    <= 1'b1;
            mask_data  <= pix[0];
            busy       <= 1'b1;
            done       <= 1'b0;
            iter_count <= '0;
            converged  <= 1'b0;
            timeout    <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skeleton_frame_controller.sv
// Bench for skeleton_frame_controller: plays the mask stage with several stub behaviours
// and compares the DUT against a pass-level model of the frame buffer.
module tb_skeleton_frame_controller;

  localparam int N    = 8;
  localparam int BS   = 6;
  localparam int NN   = N * N;
  localparam int MAXI = 3;

  typedef enum int {M_ECHO, M_Z910, M_FLIP20, M_RAND, M_SILENT} mode_t;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        start;
  logic        wr_en;
  logic [BS:0] wr_addr;
  logic [7:0]  wr_data;
  logic        mask_we;
  logic [7:0]  mask_data;
  logic [BS:0] rd_addr;
  logic [7:0]  rd_data;
  logic        busy;
  logic        done;
  logic        converged;
  logic        timeout;
  logic [7:0]  iter_count;
  logic [BS:0] changed_count;

  skeleton_frame_controller #(.N(N), .bitSize(BS), .MAX_ITER(MAXI)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .start        (start),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .mask_we      (mask_we),
    .mask_data    (mask_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .converged    (converged),
    .timeout      (timeout),
    .iter_count   (iter_count),
    .changed_count(changed_count)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_pass;
  logic [7:0] mbuf [NN];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic load_image(input bit ramp);
    for (int i = 0; i < NN; i++) begin
      load_valid = 1'b1;
      load_data  = ramp ? 8'(i) : 8'($urandom);
      mbuf[i]    = load_data;
      @(negedge clk);
    end
    load_valid = 1'b0;
  endtask

  task automatic readback();
    for (int a = 0; a < NN; a++) begin
      rd_addr = 7'(a);
      #1 check_val("rd_data", rd_data, mbuf[a]);
    end
    rd_addr = 7'($urandom_range(NN, 127));
    #1 check_val("rd_out_of_range", rd_data, 0);
  endtask

  // One start-to-done job; the bench acts as the mask stage.
  task automatic run(input mode_t mode, input int rand_passes);
    logic [7:0] nv [NN];
    int changed, miter, k, oor_at;
    bit fin;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("start_busy", busy, 1);
    check_val("start_timeout_clear", timeout, 0);
    check_val("start_iter_clear", iter_count, 0);
    check_val("start_done_clear", done, 0);
    miter = 0;
    fin = 0;
    while (!fin) begin
      for (int c = 0; c < 2 * NN; c++) begin
        check_val("replay_we", mask_we, 1);
        check_val("replay_data", mask_data, mbuf[c / 2]);
        @(negedge clk);
      end
      check_val("collect_we_low", mask_we, 0);
      check_val("collect_busy", busy, 1);
      if (mode == M_SILENT) begin
        k = 0;
        while (!done && k < 1000) begin
          @(negedge clk);
          k++;
        end
        check_val("timeout_cycles", k, 256);
        check_val("timeout_flag", timeout, 1);
        check_val("timeout_iter", iter_count, 0);
        check_val("timeout_converged", converged, 0);
        return;
      end
      miter++;
      changed = 0;
      for (int a = 0; a < NN; a++) begin
        nv[a] = mbuf[a];
        case (mode)
          M_Z910:   if (miter == 1 && (a == 9 || a == 10)) nv[a] = 8'd0;
          M_FLIP20: if (a == 20) nv[a] = mbuf[a] ^ 8'd1;
          M_RAND:   if (miter <= rand_passes && $urandom_range(0, 3) == 0) nv[a] = 8'($urandom);
          default:  ;
        endcase
        if (nv[a] != mbuf[a]) changed++;
      end
      oor_at = $urandom_range(1, NN - 1);
      for (int a = 0; a < NN; a++) begin
        if (a == oor_at) begin
          wr_en   = 1'b1;
          wr_addr = 7'($urandom_range(NN, 127));
          wr_data = 8'($urandom);
          @(negedge clk);
        end
        wr_en   = 1'b1;
        wr_addr = 7'(a);
        wr_data = nv[a];
        @(negedge clk);
        @(negedge clk);
      end
      wr_en = 1'b0;
      for (int a = 0; a < NN; a++) mbuf[a] = nv[a];
      @(negedge clk);
      check_val("check_changed", changed_count, changed);
      check_val("check_busy", busy, 1);
      @(negedge clk);
      check_val("iter_count", iter_count, miter);
      if (changed == 0 || miter == MAXI) begin
        fin = 1;
        check_val("done", done, 1);
        check_val("done_busy", busy, 0);
        check_val("converged", converged, (changed == 0) ? 1 : 0);
        check_val("done_timeout", timeout, 0);
        check_val("done_we", mask_we, 0);
      end else begin
        check_val("next_pass_done", done, 0);
      end
    end
    readback();
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    clk = 0;
    rst_n = 0;
    load_valid = 0;
    load_data = 0;
    start = 0;
    wr_en = 0;
    wr_addr = 0;
    wr_data = 0;
    rd_addr = 0;
    #12;
    check_val("rst_mask_we", mask_we, 0);
    check_val("rst_mask_data", mask_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_flags", {converged, timeout}, 0);
    check_val("rst_iter", iter_count, 0);
    check_val("rst_changed", changed_count, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    load_image(1'b1);
    run(M_ECHO, 0);
    run(M_Z910, 0);
    run(M_FLIP20, 0);
    check_val("flip_changed_final", changed_count, 1);
    run(M_SILENT, 0);
    run(M_ECHO, 0);

    // Loads are ignored once the controller sits in DONE.
    load_valid = 1'b1;
    load_data  = ~mbuf[0];
    @(negedge clk);
    load_valid = 1'b0;
    rd_addr = '0;
    #1 check_val("done_load_ignored", rd_data, mbuf[0]);

    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    load_image(1'b0);
    run(M_RAND, 2);
    run(M_RAND, 1);

    // Abort in the middle of a replay.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check_val("pre_abort_we", mask_we, 1);
    #2 rst_n = 0;
    #1;
    check_val("abort_we", mask_we, 0);
    check_val("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = ~mbuf[0];
    @(negedge clk);
    load_valid = 1'b0;
    mbuf[0] = load_data;
    rd_addr = 7'd0;
    #1 check_val("abort_load_ptr0", rd_data, mbuf[0]);
    rd_addr = 7'd5;
    #1 check_val("abort_keep_pix5", rd_data, mbuf[5]);
    check_val("abort_idle_done", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/skeleton_frame_controller.md
Name: skeleton_frame_controller

Overview:
- Frame-level controller directly downstream of the convolutional mask stage; also closes the loop back into it.
- Holds the N*N working image, replays it into the mask stage's load port, and collects the mask stage's write-back stream (address/value/enable).
- Counts changed pixels per pass and repeats thinning passes until no pixel changes or an iteration cap is reached.
- Host loads and reads the image through side ports.

Parameters:
- N, 8, image side length; frame is N*N pixels, row-major.
- bitSize, 6, address MSB index; addresses are bitSize+1 bits wide, and N*N must be at most 2^(bitSize+1).
- MAX_ITER, 16, maximum thinning passes per start (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  host pixel write strobe; honoured only in IDLE.
- load_data  in  8  host pixel value.
- start  in  1  begin passes; honoured only in IDLE or DONE.
- wr_en  in  1  write-back enable from mask stage.
- wr_addr  in  bitSize+1  write-back pixel address.
- wr_data  in  8  write-back pixel value.
- mask_we  out  1  load enable to mask stage.
- mask_data  out  8  pixel value to mask stage.
- rd_addr  in  bitSize+1  host readback address.
- rd_data  out  8  buf[rd_addr], combinational; 0 if rd_addr >= N*N.
- busy  out  1  high in REPLAY/COLLECT/CHECK.
- done  out  1  high in DONE.
- converged  out  1  valid in DONE: last pass changed zero pixels.
- timeout  out  1  valid in DONE: mask stage never returned data.
- iter_count  out  8  passes completed since start.
- changed_count  out  bitSize+1  pixels changed in the current or last pass; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0) clears:
  - state to IDLE; load_ptr, replay_ptr and timers to 0.
  - all outputs to 0 except rd_data.
  - Buffer contents are not reset.
- Reset mid-pass aborts immediately; mask_we drops in the same instant.
- IDLE:
  - Each load_valid cycle writes buf[load_ptr]=load_data and increments load_ptr, wrapping N*N-1 -> 0.
  - start -> REPLAY: clears iter_count, converged, timeout; resets load_ptr.
  - If start and load_valid occur together, the load write happens first, then the transition.
- REPLAY:
  - Lasts exactly 2*N*N cycles with mask_we=1 throughout.
  - mask_data=buf[replay_ptr] is registered; each pixel is held for 2 consecutive cycles because the mask stage samples on alternate cycles.
  - Pixel k is presented in cycles 2k and 2k+1 of the state.
  - After the last cycle, mask_we=0 and the state goes to COLLECT; changed_count, seen_wr, last_addr and the timer are cleared.
- COLLECT:
  - Accept a write-back when wr_en=1, wr_addr < N*N, and (seen_wr=0 or wr_addr != last_addr). Duplicates from the mask stage's 2-cycle hold are dropped.
  - On accept: if wr_data != buf[wr_addr], increment changed_count (saturating); then buf[wr_addr]<=wr_data, last_addr<=wr_addr, seen_wr<=1.
  - wr_en with wr_addr >= N*N is ignored but still sets seen_wr.
  - seen_wr=1 and wr_en=0 -> CHECK. The end of a stream is the falling edge of wr_en.
  - seen_wr=0 for 4*N*N cycles -> DONE with timeout=1; iter_count is not incremented.
- CHECK (1 cycle):
  - iter_count++.
  - If changed_count==0 -> DONE with converged=1.
  - Else if iter_count (new value)==MAX_ITER -> DONE with converged=0.
  - Else -> REPLAY.
- DONE:
  - done=1, status outputs held.
  - start -> REPLAY on the current buffer, clearing status as in IDLE.
  - load_valid is ignored.
- start or load_valid outside the states above is ignored.
- rd_addr reads are always permitted.
  - A read of the address being written in the same cycle returns the old value.

Test Plan:
- Load 64 pixels 0..63, then start -> mask_we high for 128 cycles; mask_data=0,0,1,1,...,63,63; busy=1; state then COLLECT.
- Stub mask stage echoes all 64 pixels unchanged, each held 2 cycles -> CHECK gives changed_count=0, iter_count=1, done=1, converged=1.
- Stub zeroes pixels 9 and 10 on pass 1, echoes unchanged on pass 2 -> pass 1 changed_count=2, second REPLAY occurs, final iter_count=2, converged=1, rd_data(9)=0.
- MAX_ITER=3 with a stub that always flips pixel 20 -> done after iter_count=3, converged=0, changed_count=1.
- No wr_en after REPLAY -> after 256 cycles done=1, timeout=1, iter_count=0; a following start restarts REPLAY with timeout cleared.
- Deassert rst_n mid-REPLAY (cycle 40) -> mask_we=0 and busy=0 asynchronously; after release, state is IDLE and load_ptr=0; the buffer keeps its earlier pixels (rd_data(5)=5).
